// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHANGE  = 2'd2
  } vend_state_t;

  localparam int PRICE_VEC_MAX = 256;

  // Item 0 sits in the least significant CW bits.
  localparam logic [31:0] DEF_PRICES = {8'd20, 8'd15, 8'd10, 8'd5};

  // Price of item idx from a packed price vector with cw-bit fields (cw < 32).
  function automatic logic [31:0] price_of(input logic [PRICE_VEC_MAX-1:0] prices,
                                           input int unsigned idx,
                                           input int unsigned cw);
    logic [PRICE_VEC_MAX-1:0] sh;
    sh = prices >> (idx * cw);
    return sh[31:0] & ((32'd1 << cw) - 32'd1);
  endfunction

endpackage

// File: rtl/vend_if.sv
// Coin-acceptor / dispenser handshake bundle for vend_ctrl_multi.
interface vend_if #(
  parameter int N_ITEMS = 4,
  parameter int CW      = 8,
  parameter int COIN_W  = 6
);
  localparam int IW = $clog2(N_ITEMS);

  logic              sel_valid;
  logic [IW-1:0]     sel_item;
  logic              coin_valid;
  logic [COIN_W-1:0] coin_amt;
  logic              cancel;
  logic              busy;
  logic [CW-1:0]     credit;
  logic              drink_valid;
  logic [IW-1:0]     drink_id;
  logic              change_pulse;
  logic              change_done;
  logic              coin_rej;

  modport master (
    output sel_valid, sel_item, coin_valid, coin_amt, cancel,
    input  busy, credit, drink_valid, drink_id, change_pulse, change_done, coin_rej
  );

  modport slave (
    input  sel_valid, sel_item, coin_valid, coin_amt, cancel,
    output busy, credit, drink_valid, drink_id, change_pulse, change_done, coin_rej
  );
endinterface

// File: rtl/vend_change_ser.sv
// One step of the change train: pay out one CHG_UNIT, or finish and drop the residue.
// Shared by the purchase and refund paths, which both drain credit through CHANGE.
module vend_change_ser #(
  parameter int CW       = 8,
  parameter int CHG_UNIT = 5
) (
  input  logic [CW-1:0] credit,
  output logic [CW-1:0] credit_nxt,
  output logic          pulse,
  output logic          done
);
  localparam logic [CW-1:0] UNIT = CW'(CHG_UNIT);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    credit_nxt = '0;
    pulse      = 1'b0;
    done       = 1'b0;
    if (credit >= UNIT) begin
      pulse      = 1'b1;
      credit_nxt = credit - UNIT;
    end else begin
      done = 1'b1;
    end
  end
endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: select, collect coins, dispense, then serial change.
// Cancel and inactivity timeout both fall through to the change path as a refund.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                    N_ITEMS  = 4,
  parameter int                    CW       = 8,
  parameter int                    COIN_W   = 6,
  parameter logic [N_ITEMS*CW-1:0] PRICES   = DEF_PRICES,
  parameter int                    CHG_UNIT = 5,
  parameter int                    TIMEOUT  = 16
) (
  input logic   clk,
  input logic   rst_n,
  vend_if.slave bus
);
  localparam int IW = $clog2(N_ITEMS);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  vend_state_t   state_q, state_d;
  logic [IW-1:0] item_q, item_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [IW-1:0] drink_id_q, drink_id_d;
  logic          drink_valid_q, drink_valid_d;
  logic          change_pulse_q, change_pulse_d;
  logic          change_done_q, change_done_d;
  logic          coin_rej_q, coin_rej_d;

  logic [CW:0]   sum;
  logic [CW-1:0] price;
  logic [CW-1:0] ser_credit;
  logic          ser_pulse;
  logic          ser_done;
  logic          tmo_hit;

  assign sum     = {1'b0, credit_q} + (CW+1)'(bus.coin_amt);
  assign price   = CW'(price_of(PRICE_VEC_MAX'(PRICES), 32'(item_q), CW));
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

  vend_change_ser #(.CW(CW), .CHG_UNIT(CHG_UNIT)) u_change_ser (
    .credit     (credit_q),
    .credit_nxt (ser_credit),
    .pulse      (ser_pulse),
    .done       (ser_done)
  );

  always_comb begin
    state_d        = state_q;
    item_d         = item_q;
    credit_d       = credit_q;
    tmo_d          = tmo_q;
    drink_id_d     = drink_id_q;
    drink_valid_d  = 1'b0;
    change_pulse_d = 1'b0;
    change_done_d  = 1'b0;
    coin_rej_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d      = '0;
        coin_rej_d = bus.coin_valid;
        if (bus.sel_valid) begin
          item_d   = (32'(bus.sel_item) >= N_ITEMS) ? IW'(N_ITEMS - 1) : bus.sel_item;
          credit_d = '0;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.cancel || tmo_hit) begin
          coin_rej_d = bus.coin_valid;
          tmo_d      = '0;
          state_d    = CHANGE;
        end else if (bus.coin_valid && !sum[CW]) begin
          tmo_d = '0;
          if (sum[CW-1:0] >= price) begin
            drink_valid_d = 1'b1;
            drink_id_d    = item_q;
            credit_d      = sum[CW-1:0] - price;
            state_d       = CHANGE;
          end else begin
            credit_d = sum[CW-1:0];
          end
        end else begin
          // Overflowing coins are refused and count as an idle cycle.
          coin_rej_d = bus.coin_valid;
          if (TIMEOUT != 0) tmo_d = tmo_q + 1'b1;
        end
      end
      CHANGE: begin
        coin_rej_d     = bus.coin_valid;
        credit_d       = ser_credit;
        change_pulse_d = ser_pulse;
        change_done_d  = ser_done;
        if (ser_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      item_q         <= '0;
      credit_q       <= '0;
      tmo_q          <= '0;
      drink_id_q     <= '0;
      drink_valid_q  <= 1'b0;
      change_pulse_q <= 1'b0;
      change_done_q  <= 1'b0;
      coin_rej_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      item_q         <= item_d;
      credit_q       <= credit_d;
      tmo_q          <= tmo_d;
      drink_id_q     <= drink_id_d;
      drink_valid_q  <= drink_valid_d;
      change_pulse_q <= change_pulse_d;
      change_done_q  <= change_done_d;
      coin_rej_q     <= coin_rej_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.credit       = credit_q;
  assign bus.drink_valid  = drink_valid_q;
  assign bus.drink_id     = drink_id_q;
  assign bus.change_pulse = change_pulse_q;
  assign bus.change_done  = change_done_q;
  assign bus.coin_rej     = coin_rej_q;
endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised multi-item drink vending controller.
- Accepts an item selection, then accumulates coin credit over any number of cycles.
- Dispenses once credit reaches the item price, then returns change as a serial train of fixed-value pulses.
- Adds cancel/refund, inactivity timeout, coin rejection on credit overflow, and a visible credit value.
- Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
N_ITEMS, 4, number of selectable drinks (>=2)
CW, 8, credit/price width in $1 units
COIN_W, 6, coin amount width in $1 units
PRICES, {8'd20,8'd15,8'd10,8'd5}, packed N_ITEMS*CW price vector; item i price = PRICES[i*CW +: CW]; item0 = 5
CHG_UNIT, 5, value of one change pulse in $
TIMEOUT, 16, idle cycles in COLLECT before auto-refund; 0 disables

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
sel_valid  in  1  item selection strobe; honoured only in IDLE
sel_item  in  $clog2(N_ITEMS)  selected item index
coin_valid  in  1  coin inserted this cycle
coin_amt  in  COIN_W  coin value in $
cancel  in  1  refund request
busy  out  1  high when state != IDLE
credit  out  CW  current credit
drink_valid  out  1  one-cycle dispense pulse
drink_id  out  $clog2(N_ITEMS)  item dispensed; valid with drink_valid
change_pulse  out  1  one pulse per CHG_UNIT returned
change_done  out  1  one-cycle pulse when the change train ends
coin_rej  out  1  one-cycle pulse when an offered coin is refused

Behaviour:
- Reset: state=IDLE; credit, drink_valid, drink_id, change_pulse, change_done, coin_rej and the timeout counter all 0.
- All outputs are registered. Response appears at the clock edge that samples the stimulus, i.e. visible one cycle after it is driven.
- States are IDLE, COLLECT and CHANGE.
- IDLE:
  - sel_valid: latch sel_item; sel_item >= N_ITEMS clamps to N_ITEMS-1; credit=0; go to COLLECT.
  - coin_valid in IDLE: coin_rej=1; credit unchanged.
- COLLECT, priority cancel > timeout > coin:
  - cancel: go to CHANGE with current credit. A coin offered in the same cycle is refused (coin_rej=1).
  - Timeout: counter increments each cycle without an accepted coin and clears on acceptance. When TIMEOUT!=0 and the counter reaches TIMEOUT-1, go to CHANGE.
  - Coin check: sum = credit + coin_amt, computed at CW+1 bits. If sum > 2^CW-1, set coin_rej=1 and leave credit unchanged; otherwise accept the coin.
  - Accepted coin with sum >= price: drink_valid=1, drink_id=latched item, credit = sum - price, go to CHANGE, all at the same edge.
  - Accepted coin with sum < price: credit = sum; stay in COLLECT.
  - sel_valid is ignored.
- CHANGE:
  - While credit >= CHG_UNIT: change_pulse=1 and credit -= CHG_UNIT, one unit per cycle.
  - When credit < CHG_UNIT: clear the residue to 0, assert change_done=1, return to IDLE.
  - Zero-change purchase: change_done asserts in the first CHANGE cycle.
  - Coins are refused (coin_rej); sel_valid and cancel are ignored.
- Reset mid-operation: credit is discarded, with no refund pulses; the block returns to the reset state.

Decomposition:
- Package vend_pkg holds:
  - the state enum {IDLE, COLLECT, CHANGE};
  - the default price vector constant;
  - a function price_of(prices, idx).
- One sub-module, vend_change_ser: loads credit, emits change_pulse per CHG_UNIT, and signals done. It is reusable by the refund and purchase paths.

Test Plan:
- Exact pay: sel item1 ($10), coin 5, then coin 5 -> drink_valid with drink_id=1 on the edge sampling the second coin; credit=0; next cycle change_done with no change_pulse; busy drops.
- Overpay: sel item0 ($5), coin 20 -> drink_valid, credit=15; then 3 consecutive change_pulse cycles (credit 10, 5, 0); then change_done; IDLE.
- Cancel: sel item3 ($20), coins 10, 5, then cancel together with a 5 coin -> coin_rej=1; 3 change_pulses; change_done; no drink_valid.
- Timeout: sel item2 with TIMEOUT=16, coin 5, then 16 quiet cycles -> 1 change_pulse followed by change_done; IDLE.
- Overflow: CW=6, sel item3 with PRICES=20, coins 10, then 63 (COIN_W=6) -> second coin refused with coin_rej; credit stays 10.
- Reset mid-COLLECT with credit=15 -> all outputs 0, no pulses; coin_valid in IDLE -> coin_rej only.
